// File: rtl/seq_adder_pkg.sv
// rtl/seq_adder_pkg.sv - shared state encoding and sizing helpers for seq_chunk_adder
// Contents:
//   state_t    : IDLE / RUN / DONE controller states
//   cnt_width  : chunk counter width, clog2(nch) with a minimum of 1 bit
package seq_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A single-chunk build still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_fadder_chunk.sv
// rtl/seq_chunk_adder_fadder_chunk.sv - combinational CHUNK-bit ripple-carry adder slice
// Module fadder_chunk
//   a, b  in  CHUNK  addend slices
//   cin   in  1      carry into bit 0
//   sum   out CHUNK  slice sum
//   cout  out 1      carry out of the top bit
module fadder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] cy;

  assign cy[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign cout = cy[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked ripple adder with valid/ready handshakes
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready operand handshake (x, y, z captured on accept)
//   x, y                WIDTH-bit operands
//   z                   carry-in
//   sub                 subtract select, present only with SEQ_CHUNK_ADDER_SUB_EN defined
//   out_valid/out_ready result handshake
//   s, c                WIDTH-bit sum and carry-out of the MSB
// Optional build macro: SEQ_CHUNK_ADDER_SUB_EN (adds sub; effective B = ~y, carry-in = z ^ sub)
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             z,
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = cnt_width(NCH);
  localparam logic [CW-1:0]    LAST  = CW'(NCH - 1);
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});

  if ((CHUNK < 1) || (CHUNK > WIDTH) || (WIDTH % CHUNK != 0)) begin : g_param_check
    $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cr;

  logic [WIDTH-1:0] y_eff;
  logic             z_eff;

`ifdef SEQ_CHUNK_ADDER_SUB_EN
  // Two's-complement subtract: x + ~y + 1 when z=0, x + ~y when z=1 (x-y-1).
  assign y_eff = sub ? ~y : y;
  assign z_eff = z ^ sub;
`else
  assign y_eff = y;
  assign z_eff = z;
`endif

  // Chunk selection by shifting keeps the variable-index widths self-consistent.
  int               sh;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK-1:0] sum_ch;
  logic             cout_ch;

  assign sh   = int'(cnt) * CHUNK;
  assign a_sh = a >> sh;
  assign b_sh = b >> sh;

  fadder_chunk #(.CHUNK(CHUNK)) u_fa (
    .a    (a_sh[CHUNK-1:0]),
    .b    (b_sh[CHUNK-1:0]),
    .cin  (cr),
    .sum  (sum_ch),
    .cout (cout_ch)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      cr    <= 1'b0;
      s     <= '0;
      c     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a     <= x;
            b     <= y_eff;
            cr    <= z_eff;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          s  <= (s & ~(CMASK << sh)) | (WIDTH'(sum_ch) << sh);
          cr <= cout_ch;
          if (cnt == LAST) begin
            c     <= cout_ch;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          // No re-accept in this cycle; in_ready returns once IDLE is registered.
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
